// File: rtl/scope_pkg.sv
// Shared types and helpers for the triggered two-channel scope capture stage.
package scope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRIG,
    ST_POST,
    ST_READOUT
  } cap_state_t;

  // Record length for a given buffer address width.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Readout stream of a captured record: one beat carries both channels.
interface scope_capture_if #(
  parameter int unsigned D_WIDTH = 8
) ();

  logic               rd_valid;
  logic               rd_ready;
  logic [D_WIDTH-1:0] rd_data1;
  logic [D_WIDTH-1:0] rd_data2;
  logic               rd_last;

  modport master (output rd_valid, rd_data1, rd_data2, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data1, rd_data2, rd_last, output rd_ready);

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
module capture_ram
  import scope_pkg::*;
#(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned W       = 16
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [W-1:0]       wr_data,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [W-1:0]       rd_data
);

  localparam int unsigned DEPTH = depth_of(A_WIDTH);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered two-channel capture: circular pre/post-trigger buffering, then
// oldest-first readout through a 2-entry skid that hides RAM read latency.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din1,
  input  logic [D_WIDTH-1:0] din2,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic [A_WIDTH-1:0] pre_count,
  output logic               busy,
  scope_capture_if.master    rd,
  output logic               done
);

  localparam int unsigned DEPTH = depth_of(A_WIDTH);
  localparam int unsigned CW    = A_WIDTH + 1;
  localparam int unsigned RW    = 2 * D_WIDTH;

  cap_state_t state, state_next;

  logic [A_WIDTH-1:0] pc, wp, cnt, ra;
  logic [CW-1:0]      issue_left;
  logic [D_WIDTH-1:0] prev1;
  logic               hist;
  logic               inflight, inflight_last;

  logic               skid_valid, skid_last;
  logic [D_WIDTH-1:0] skid_d1, skid_d2;

  logic [RW-1:0]      ram_q;
  logic               wr_c, trig_c, issue_c, pop_c;
  logic [1:0]         occ_c;

  capture_ram #(.A_WIDTH(A_WIDTH), .W(RW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_c),
    .wr_addr (wp),
    .wr_data ({din2, din1}),
    .rd_en   (issue_c),
    .rd_addr (ra),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (arm) state_next = (pre_count != '0) ? ST_PRE : ST_WAIT_TRIG;
      ST_PRE:       if (en && cnt == A_WIDTH'(1)) state_next = ST_WAIT_TRIG;
      // ~pc == 0 means the trigger sample alone completes the record
      ST_WAIT_TRIG: if (trig_c) state_next = (&pc) ? ST_READOUT : ST_POST;
      ST_POST:      if (en && cnt == A_WIDTH'(1)) state_next = ST_READOUT;
      ST_READOUT:   if (pop_c && rd.rd_last) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Per-cycle strobes: sample write, trigger hit, RAM read issue, beat pop.
  always_comb begin
    wr_c    = 1'b0;
    trig_c  = 1'b0;
    issue_c = 1'b0;
    pop_c   = rd.rd_valid & rd.rd_ready;
    occ_c   = 2'(rd.rd_valid) + 2'(skid_valid) + 2'(inflight) - 2'(pop_c);
    unique case (state)
      ST_PRE, ST_POST: wr_c = en;
      ST_WAIT_TRIG: begin
        wr_c   = en;
        trig_c = en & hist & (prev1 < trig_level) & (din1 >= trig_level);
      end
      ST_READOUT: issue_c = (issue_left != '0) && (occ_c < 2'd2);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      wp            <= '0;
      cnt           <= '0;
      ra            <= '0;
      issue_left    <= '0;
      prev1         <= '0;
      hist          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= pop_c & rd.rd_last;
      if (done) busy <= 1'b0;
      if (state == ST_IDLE && arm) begin
        pc   <= pre_count;
        cnt  <= pre_count;
        wp   <= '0;
        hist <= 1'b0;
        busy <= 1'b1;
      end
      if (wr_c) begin
        wp    <= wp + A_WIDTH'(1);
        prev1 <= din1;
        hist  <= 1'b1;
      end
      if (wr_c && (state == ST_PRE || state == ST_POST)) cnt <= cnt - A_WIDTH'(1);
      // Remaining post-trigger writes after the trigger sample: DEPTH-pc-1 == ~pc
      if (trig_c) begin
        cnt        <= ~pc;
        ra         <= wp - pc;
        issue_left <= CW'(DEPTH);
      end
      inflight      <= issue_c;
      inflight_last <= issue_c && (issue_left == CW'(1));
      if (issue_c) begin
        ra         <= ra + A_WIDTH'(1);
        issue_left <= issue_left - CW'(1);
      end
    end
  end

  // Output head plus one skid entry; reads are only issued when both fit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data1 <= '0;
      rd.rd_data2 <= '0;
      rd.rd_last  <= 1'b0;
      skid_valid  <= 1'b0;
      skid_d1     <= '0;
      skid_d2     <= '0;
      skid_last   <= 1'b0;
    end else if (pop_c && skid_valid) begin
      rd.rd_data1 <= skid_d1;
      rd.rd_data2 <= skid_d2;
      rd.rd_last  <= skid_last;
      skid_valid  <= inflight;
      skid_d1     <= ram_q[D_WIDTH-1:0];
      skid_d2     <= ram_q[RW-1:D_WIDTH];
      skid_last   <= inflight_last;
    end else if (pop_c || !rd.rd_valid) begin
      rd.rd_valid <= inflight;
      rd.rd_data1 <= ram_q[D_WIDTH-1:0];
      rd.rd_data2 <= ram_q[RW-1:D_WIDTH];
      rd.rd_last  <= inflight_last;
    end else if (inflight) begin
      skid_valid  <= 1'b1;
      skid_d1     <= ram_q[D_WIDTH-1:0];
      skid_d2     <= ram_q[RW-1:D_WIDTH];
      skid_last   <= inflight_last;
    end
  end

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: directed capture scenarios with
// hand-derived record contents, checked by an independent readout monitor.
module tb_scope_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] din1 = '0;
  logic [7:0] din2 = '0;
  logic [7:0] trig_level = '0;
  logic [7:0] pre_count = '0;
  logic       busy, done;

  scope_capture_if #(.D_WIDTH(8)) rd_if ();

  scope_capture #(.D_WIDTH(8), .A_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din1       (din1),
    .din2       (din2),
    .arm        (arm),
    .trig_level (trig_level),
    .pre_count  (pre_count),
    .busy       (busy),
    .rd         (rd_if),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    beat_cnt = 0;
  int    cur_test = 0;
  bit    last_xfer = 1'b0;
  bit    held = 1'b0;
  beat_t held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Sample stream per scenario: {din2, din1} for the s-th enabled sample.
  function automatic logic [15:0] gen(input int tid, input int s);
    logic [7:0] a, b;
    case (tid)
      3: begin
        if (s < 3)      a = 8'd200;
        else if (s < 6) a = 8'd100;
        else            a = 8'(150 + s - 6);
        b = ~a;
      end
      5: begin
        if (s < 1000)       begin a = 8'(s % 100); b = 8'(s); end
        else if (s == 1000) begin a = 8'd200;      b = 8'd232; end
        else                begin a = 8'd0;        b = 8'd0;   end
      end
      default: begin a = 8'(s); b = ~a; end
    endcase
    return {b, a};
  endfunction

  // Expected k-th beat of the record for each scenario.
  function automatic beat_t expb(input int tid, input int k);
    beat_t r;
    case (tid)
      2: r.d1 = 8'(128 + k);
      3: r.d1 = 8'(150 + k);
      5: r.d1 = (k < 255) ? 8'((745 + k) % 100) : 8'd200;
      default: r.d1 = 8'(64 + k);
    endcase
    if (tid == 5) r.d2 = (k < 255) ? 8'(745 + k) : 8'd232;
    else          r.d2 = ~r.d1;
    r.last = (k == 255);
    return r;
  endfunction

  // Readout monitor: pops the scoreboard on every transfer.
  always @(negedge clk) begin
    beat_t cur, e;
    cur.d1   = rd_if.rd_data1;
    cur.d2   = rd_if.rd_data2;
    cur.last = rd_if.rd_last;
    if (rst) begin
      last_xfer = 1'b0;
      held      = 1'b0;
    end else begin
      if (last_xfer)  check($sformatf("t%0d_done_after_last", cur_test), 32'(done), 32'd1);
      else if (done)  check($sformatf("t%0d_unexpected_done", cur_test), 32'(done), 32'd0);
      last_xfer = 1'b0;
      if (held) begin
        check($sformatf("t%0d_hold_valid", cur_test), 32'(rd_if.rd_valid), 32'd1);
        check($sformatf("t%0d_hold_data", cur_test), 32'(cur), 32'(held_b));
      end
      held   = rd_if.rd_valid && !rd_if.rd_ready;
      held_b = cur;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("t%0d_extra_beat", cur_test), 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("t%0d_beat%0d_d1", cur_test, beat_cnt), 32'(cur.d1), 32'(e.d1));
          check($sformatf("t%0d_beat%0d_d2", cur_test, beat_cnt), 32'(cur.d2), 32'(e.d2));
          check($sformatf("t%0d_beat%0d_last", cur_test, beat_cnt), 32'(cur.last), 32'(e.last));
        end
        beat_cnt++;
        if (cur.last) last_xfer = 1'b1;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd0);
    check({tag, "_last"},  32'(rd_if.rd_last), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_d1"},    32'(rd_if.rd_data1), 32'd0);
    check({tag, "_d2"},    32'(rd_if.rd_data2), 32'd0);
  endtask

  task automatic run_test(input int tid, input logic [7:0] pc, input logic [7:0] lvl,
                          input bit stall, input int abort_at, input bit noisy_arm);
    int s = 0;
    int base;
    bit got_done = 1'b0;
    cur_test = tid;
    base     = beat_cnt;
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(expb(tid, k));

    @(posedge clk); #1;
    arm = 1'b1; pre_count = pc; trig_level = lvl; en = 1'b0;
    rd_if.rd_ready = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    check($sformatf("t%0d_busy_after_arm", tid), 32'(busy), 32'd1);

    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done) begin got_done = 1'b1; break; end
      if (abort_at > 0 && (beat_cnt - base) >= abort_at) break;
      en = stall ? (cyc % 2 == 1) : 1'b1;
      if (en) begin
        {din2, din1} = gen(tid, s);
        s++;
      end
      rd_if.rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      arm       = noisy_arm && (cyc % 37 == 5);
      pre_count = noisy_arm ? 8'd5 : pc;
      @(posedge clk); #1;
    end
    en  = 1'b0;
    arm = 1'b0;

    if (abort_at > 0) begin
      check($sformatf("t%0d_abort_reached", tid), 32'((beat_cnt - base) >= abort_at), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero($sformatf("t%0d_after_rst", tid));
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check($sformatf("t%0d_busy_after_abort", tid), 32'(busy), 32'd0);
    end else begin
      check($sformatf("t%0d_done_seen", tid), 32'(got_done), 32'd1);
      if (got_done) begin
        @(posedge clk); #1;
        check($sformatf("t%0d_busy_after_done", tid), 32'(busy), 32'd0);
        check($sformatf("t%0d_done_one_cycle", tid), 32'(done), 32'd0);
        check($sformatf("t%0d_beat_count", tid), 32'(beat_cnt - base), 32'd256);
        check($sformatf("t%0d_queue_drained", tid), 32'(exp_q.size()), 32'd0);
      end
    end
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_test(1, 8'd64,  8'd128, 1'b0, 0,   1'b0);  // basic ramp trigger
    run_test(2, 8'd0,   8'd128, 1'b0, 0,   1'b0);  // no pre-trigger samples
    run_test(3, 8'd0,   8'd128, 1'b0, 0,   1'b0);  // no trigger on first/falling samples
    run_test(4, 8'd64,  8'd128, 1'b1, 0,   1'b0);  // en stalls and readout backpressure
    run_test(5, 8'd255, 8'd128, 1'b0, 0,   1'b0);  // buffer wraps before late trigger
    run_test(6, 8'd64,  8'd128, 1'b0, 100, 1'b0);  // reset during readout
    run_test(6, 8'd64,  8'd128, 1'b0, 0,   1'b1);  // re-arm, stray arms while busy

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
# scope_capture

Triggered two-channel sample capture stage placed directly downstream of the sine generator, consuming its `dout1`/`dout2` pair. Once armed, it buffers samples continuously in a circular RAM and waits for a rising level crossing on channel 1. It then completes a fixed-length record around that trigger and streams the record out over a valid/ready interface to the plotting/testbench side, oldest sample first.

## Interface

Parameters:
- `D_WIDTH`, 8: sample width per channel. Samples are unsigned, offset binary.
- `A_WIDTH`, 8: buffer address width. Record length `DEPTH = 2**A_WIDTH`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: sample strobe. `din1`/`din2` are taken only on cycles with `en=1`.
- `din1`  in  D_WIDTH: channel 1 sample (trigger source).
- `din2`  in  D_WIDTH: channel 2 sample.
- `arm`  in  1: start a capture. Sampled only in IDLE.
- `trig_level`  in  D_WIDTH: trigger threshold, unsigned.
- `pre_count`  in  A_WIDTH: samples kept before the trigger. Latched at arm.
- `busy`  out  1: capture or readout in progress.
- `rd_valid`  out  1: readout beat valid.
- `rd_ready`  in  1: consumer accepts beat.
- `rd_data1`  out  D_WIDTH: channel 1 readout sample.
- `rd_data2`  out  D_WIDTH: channel 2 readout sample.
- `rd_last`  out  1: final beat of record (beat index DEPTH-1).
- `done`  out  1: one-cycle pulse when the last beat is accepted.

## Operation

States: IDLE, PRE, WAIT_TRIG, POST, READOUT.

- **IDLE**
  - If `arm=1`: latch `pre_count` as `pc`, clear the write pointer `wp` and the history flag.
  - Go to PRE if `pc>0`, else WAIT_TRIG.
  - `arm` in any other state is ignored.
- **PRE**
  - Each `en` cycle: write `{din2,din1}` at `wp`, increment `wp` (wraps mod DEPTH).
  - After `pc` writes, go to WAIT_TRIG.
  - Trigger detection is disabled in this state.
- **WAIT_TRIG**
  - Keep writing circularly on each `en` cycle.
  - Trigger condition, on an `en` cycle: `prev1 < trig_level` AND `din1 >= trig_level`, where `prev1` is the previous sampled `din1`.
  - `prev1` is valid only after one `en` sample since arm, so the first sample after arm never triggers.
  - On trigger: the trigger sample is written at `wp`, `start = wp - pc` (mod DEPTH), and the post counter is set to `DEPTH - pc` (trigger sample included). Go to POST, or directly to READOUT if `DEPTH - pc == 1`.
  - With no crossing, the block waits indefinitely.
- **POST**
  - Write on each `en` cycle until the post counter is exhausted, then go to READOUT.
- **READOUT**
  - Emit DEPTH beats from RAM addresses `start`, `start+1`, … (mod DEPTH).
  - Beat k carries the k-th oldest sample, so beat `pc` is the trigger sample.
  - After the beat with `rd_last=1` is accepted: pulse `done`, go to IDLE.
- **General**
  - `en` is ignored in IDLE and READOUT.
  - In capture states, `en=0` stalls all progress.
  - All comparisons are unsigned. All pointer arithmetic is mod DEPTH.

## Timing

- **Reset:** state IDLE. `busy`, `rd_valid`, `rd_last`, `done`, `rd_data1`, `rd_data2` are 0. `wp` and the history flag are cleared. RAM contents are undefined.
  - `rst` mid-capture or mid-readout aborts in the same cycle. No `done` is produced.
- **`busy`:** goes to 1 the cycle after `arm` is seen in IDLE. Returns to 0 the cycle after the `done` pulse.
- **Write path:** the RAM write occurs on the clock edge of the `en` cycle, 0 latency.
- **Readout start:** RAM read is synchronous (1 cycle). The first `rd_valid` rises no later than 2 cycles after entering READOUT.
- **Handshake:**
  - A beat transfers when `rd_valid & rd_ready`.
  - While `rd_valid=1` and `rd_ready=0`, `rd_data*` and `rd_last` hold stable.
  - `rd_valid` never drops without a transfer.
  - With `rd_ready` held high, throughput is 1 beat/cycle. No bubbles after the first beat.
- **`done`:** asserted the cycle after the last transfer, for 1 cycle.

## Structure

- Package `scope_pkg`: state enum `cap_state_t` (the five states) and a `DEPTH`-from-`A_WIDTH` helper function.
- Sub-module `capture_ram`: simple dual-port RAM, DEPTH × 2·D_WIDTH. One write port, one synchronous read port, no reset of contents.
- The top holds the FSM, the pointers and counters, and a 2-entry output buffer/skid that hides RAM read latency under backpressure.

## Test plan

- **Basic trigger:** `trig_level=128`, `pre_count=64`, ramp `din1` 0,1,2,… on every cycle with `en=1`, `din2 = ~din1`, `rd_ready=1` → 256 beats. Beat 64 has `rd_data1=128`, beat 63 has 127. `rd_last` only on beat 255. `done` pulses once. `busy` falls the next cycle.
- **pre_count=0:** same ramp → PRE is skipped. Beat 0 is the trigger sample (128).
- **No false trigger:** hold `din1=200` through arm, then drop to 100 and rise to 150 → no trigger on the first sample or while falling. Trigger occurs at the 150 sample.
- **Stall and backpressure:** `en` toggled every other cycle during capture; `rd_ready` random 50% in readout → same data sequence as the first test. `rd_data*` stable whenever `rd_valid & !rd_ready`.
- **Wrap and pointer:** `pre_count=255` with a delayed trigger (`wp` wrapped several times) → beat 255 is the trigger sample, beats 0–254 are the preceding samples in order.
- **Reset mid-readout, re-arm:** assert `rst` at beat 100 → all outputs 0 the next cycle, no `done`. A new arm completes a correct 256-beat record. `arm` pulses during busy are ignored.
